// File: rtl/imm_decode_stage.sv
// Immediate decode stage: RISC-V immediate extraction feeding a 2-entry {imm, fmt, tag} FIFO.
// Optional compressed-instruction decode is enabled by defining IMMGEN_RVC_EN.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_R   = 3'd5,
    FMT_C   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     dec;
  entry_t     head_q;
  entry_t     tail_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

`ifdef IMMGEN_RVC_EN
  logic [15:0] cir;
  assign cir = in_ir[15:0];
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_ILL;
    dec.tag = in_tag;
    if (in_ir[1:0] == 2'b11) begin
      case (in_ir[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_ir[31:20]));
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          dec.imm = XLEN'($signed({in_ir[31:25], in_ir[11:7]}));
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          dec.imm = XLEN'($signed({in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0}));
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U;
          dec.imm = XLEN'($signed({in_ir[31:12], 12'b0}));
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          dec.imm = XLEN'($signed({in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0}));
        end
        7'b0110011: dec.fmt = FMT_R;
        default: ;
      endcase
    end else begin
`ifdef IMMGEN_RVC_EN
      dec.fmt = FMT_C;
      case ({cir[1:0], cir[15:13]})
        5'b01_000, 5'b01_010:
          dec.imm = XLEN'($signed({cir[12], cir[6:2]}));
        5'b01_011:
          if (cir[11:7] != 5'd2) dec.imm = XLEN'($signed({cir[12], cir[6:2], 12'b0}));
        5'b01_001, 5'b01_101:
          dec.imm = XLEN'($signed({cir[12], cir[8], cir[10:9], cir[6], cir[7], cir[2],
                                   cir[11], cir[5:3], 1'b0}));
        5'b01_110, 5'b01_111:
          dec.imm = XLEN'($signed({cir[12], cir[6:5], cir[2], cir[11:10], cir[4:3], 1'b0}));
        5'b00_010, 5'b00_110:
          dec.imm = XLEN'({cir[5], cir[12:10], cir[6], 2'b00});
        default: ;
      endcase
`endif
    end
  end

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head slot is the one driven on out_*; the tail slot only ever refills the head.
  // NOTE: storage slots are reset too, so out_imm/out_fmt/out_tag read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= dec;
          else                 tail_q <= dec;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Push with pop only happens at count 1, so the new entry becomes the head.
        2'b11: head_q <= dec;
        default: ;
      endcase
    end
  end

  assign out_imm = head_q.imm;
  assign out_fmt = head_q.fmt;
  assign out_tag = head_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_ir;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [4:0]  out_tag;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [4:0]  out_tag64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready64), .in_ir(in_ir), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_ir = 32'hFFF00093; in_tag = 5'd9; out_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({out_valid, out_imm, out_fmt, out_tag} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b imm=%h fmt=%0d tag=%0d, want all 0",
               out_valid, out_imm, out_fmt, out_tag);
    end
    in_valid = 1'b0; rst = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_capture: out_valid got %b want 0", out_valid);
    end
  endtask

  // Push one word with out_ready=1 and check the decoded head one cycle later, then the drain.
  task automatic test_single(input string name, input logic [31:0] ir, input logic [4:0] tag,
                             input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
    in_valid = 1'b1; in_ir = ir; in_tag = tag; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== exp_imm || out_fmt !== exp_fmt || out_tag !== tag) begin
      n_fail++;
      $display("FAIL %s: got valid=%b imm=%h fmt=%0d tag=%0d, want valid=1 imm=%h fmt=%0d tag=%0d",
               name, out_valid, out_imm, out_fmt, out_tag, exp_imm, exp_fmt, tag);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_decode();
    test_single("addi_m1", 32'hFFF00093, 5'd3, 32'hFFFFFFFF, 3'd0);
    test_single("sw_m8",   32'hFE20AC23, 5'd4, 32'hFFFFFFF8, 3'd1);
    test_single("jal_m4",  32'hFFDFF06F, 5'd5, 32'hFFFFFFFC, 3'd4);
    test_single("add_r",   32'h002081B3, 5'd6, 32'h00000000, 3'd5);
    test_single("bad_op",  32'hFFFFFFFF, 5'd7, 32'h00000000, 3'd7);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'hFE000EE3; in_tag = 5'd10;
    step();
    in_ir = 32'h123450B7; in_tag = 5'd11;
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_fmt !== 3'd2 || out_tag !== 5'd10) begin
      n_fail++;
      $display("FAIL b2b_beq: got valid=%b imm=%h fmt=%0d tag=%0d, want 1 fffffffc 2 10",
               out_valid, out_imm, out_fmt, out_tag);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_fmt !== 3'd3 || out_tag !== 5'd11) begin
      n_fail++;
      $display("FAIL b2b_lui: got valid=%b imm=%h fmt=%0d tag=%0d, want 1 12345000 3 11",
               out_valid, out_imm, out_fmt, out_tag);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'h00100093; in_tag = 5'd1;
    step();
    in_ir = 32'h00200093; in_tag = 5'd2;
    step();
    in_ir = 32'h00300093; in_tag = 5'd3;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: in_ready got %b want 0", in_ready);
    end
    step(); step();
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'd1 || out_tag !== 5'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%b imm=%h tag=%0d in_ready=%b, want 1 00000001 1 0",
               out_valid, out_imm, out_tag, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'd2 || out_tag !== 5'd2) begin
      n_fail++;
      $display("FAIL bp_second: got valid=%b imm=%h tag=%0d, want 1 00000002 2",
               out_valid, out_imm, out_tag);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'd3 || out_tag !== 5'd3) begin
      n_fail++;
      $display("FAIL bp_third: got valid=%b imm=%h tag=%0d, want 1 00000003 3",
               out_valid, out_imm, out_tag);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_empty: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_rvc();
`ifdef IMMGEN_RVC_EN
    test_single("c_li_m1", 32'h000050FD, 5'd12, 32'hFFFFFFFF, 3'd6);
`else
    test_single("c_li_m1", 32'h000050FD, 5'd12, 32'h00000000, 3'd7);
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'hFFF00093; in_tag = 5'd20;
    step();
    in_tag = 5'd21;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fill: got valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    end
    rst = 1'b0; in_tag = 5'd22;
    step();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if ({out_valid, out_imm, out_fmt, out_tag} !== 41'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b imm=%h fmt=%0d tag=%0d in_ready=%b, want 0 0 0 0 1",
               out_valid, out_imm, out_fmt, out_tag, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale: cycle %0d out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_xlen64();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'h800000B7; in_tag = 5'd30;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFF80000000 ||
        out_fmt64 !== 3'd3 || out_tag64 !== 5'd30 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL lui64: got valid=%b imm=%h fmt=%0d tag=%0d rdy=%b, want 1 ffffffff80000000 3 30 1",
               out_valid64, out_imm64, out_fmt64, out_tag64, in_ready64);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_rvc();
    test_reset_mid();
    test_xlen64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the sideband tag width carried alongside each instruction.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream instruction valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-007 The block SHALL have port in_ir, input, 32 bits: instruction word; compressed instructions occupy in_ir[15:0].
REQ-008 The block SHALL have port in_tag, input, TAG_W bits: sideband tag, passed through unchanged.
REQ-009 The block SHALL have port out_valid, output, 1 bit: decoded entry valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the entry.
REQ-011 The block SHALL have port out_imm, output, XLEN bits: the extended immediate.
REQ-012 The block SHALL have port out_fmt, output, 3 bits: format code, where 0=I, 1=S, 2=B, 3=U, 4=J, 5=R (no immediate), 6=C (compressed) and 7=illegal.
REQ-013 The block SHALL have port out_tag, output, TAG_W bits: the tag of the entry at the head.

Function
REQ-014 The block SHALL be a 2-entry FIFO of {imm, fmt, tag}, with the decode done on the input side and the head entry driven on the out_* ports.
REQ-015 A transfer SHALL occur on a clock edge where valid and ready are both 1; in_ready SHALL equal (count<2).
REQ-016 Latency SHALL be 1 cycle from input transfer to out_valid, and throughput SHALL be 1 instruction per cycle while out_ready=1.
REQ-017 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 On a simultaneous push and pop the count SHALL be unchanged and order SHALL be preserved; at count=2 no push occurs, so a pop leaves count=1.
REQ-019 For in_ir[1:0]=11, the block SHALL decode by opcode in_ir[6:0] as follows:
- 0010011, 0000011, 1100111, 1110011, 0001111 -> I; imm = sext(ir[31:20]).
- 0100011 -> S; imm = sext({ir[31:25], ir[11:7]}).
- 1100011 -> B; imm = sext({ir[31], ir[7], ir[30:25], ir[11:8], 0}).
- 0110111, 0010111 -> U; imm = sext({ir[31:12], 12'b0}).
- 1101111 -> J; imm = sext({ir[31], ir[19:12], ir[20], ir[30:21], 0}).
- 0110011 -> R; imm = 0.
- any other opcode -> 7; imm = 0.
REQ-020 All sign extension SHALL be from the top immediate bit to XLEN bits; with XLEN=64, U-type SHALL sign-extend from ir[31].

Reset
REQ-021 While rst=0 at a clock edge, the block SHALL set count=0, out_valid=0, out_imm=0, out_fmt=0 and out_tag=0; in_ready SHALL be 1 on the first cycle after reset is released.
REQ-022 Reset asserted mid-operation SHALL discard all buffered entries without emitting them, and inputs presented during reset SHALL NOT be captured.

Configuration
REQ-023 The block SHALL use macro IMMGEN_RVC_EN: when defined, in_ir[1:0]!=11 SHALL decode as compressed, fmt=6, using in_ir[15:0]:
- quadrant 01, funct3 000/010 (C.ADDI/C.LI): imm = sext({ir[12], ir[6:2]}).
- quadrant 01, funct3 011 with rd!=2 (C.LUI): imm = sext({ir[12], ir[6:2], 12'b0}).
- quadrant 01, funct3 001/101 (C.JAL/C.J): imm = sext({ir[12], ir[8], ir[10:9], ir[6], ir[7], ir[2], ir[11], ir[5:3], 0}).
- quadrant 01, funct3 110/111 (C.BEQZ/C.BNEZ): imm = sext({ir[12], ir[6:5], ir[2], ir[11:10], ir[4:3], 0}).
- quadrant 00, funct3 010/110 (C.LW/C.SW): imm = zext({ir[5], ir[12:10], ir[6], 2'b00}).
- other compressed encodings: imm = 0, fmt=6.
REQ-024 When IMMGEN_RVC_EN is undefined, any in_ir[1:0]!=11 SHALL give fmt=7 and imm=0, and no compressed decode logic SHALL be present.

Verification
REQ-025 The bench SHALL drive in_ir=0xFFF00093 (addi x1,x0,-1) with tag 3 and out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=0, out_tag=3.
REQ-026 The bench SHALL drive in_ir=0xFE000EE3 (beq x0,x0,-4) followed by 0x123450B7 (lui x1,0x12345) back-to-back -> out_imm=0xFFFFFFFC with fmt=2, then 0x12345000 with fmt=3, on consecutive cycles.
REQ-027 The bench SHALL hold out_ready=0 and offer 3 instructions -> in_ready=0 after 2 are accepted; after out_ready=1, the entries SHALL drain in order with no loss or duplication.
REQ-028 The bench SHALL drive in_ir=0x000050FD (C.LI x1,-1) -> with IMMGEN_RVC_EN: out_imm=0xFFFFFFFF, fmt=6; without the macro: out_imm=0, fmt=7.
REQ-029 The bench SHALL fill the FIFO to 2 entries and then assert rst=0 for one edge -> out_valid=0, in_ready=1 and all outputs 0, with no stale entry emitted afterwards.
REQ-030 The bench SHALL run with XLEN=64 and drive in_ir=0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000.
